// File: rtl/cp0_nested_irq_pkg.sv
// Shared CP0 types: opcode/exception enums, register indices, vector constants and the save-stack entry.
package cp0_nested_irq_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [31:0] EXCEPTION_ADDRESS = 32'h8000_0000;
    localparam logic [31:0] INSTR_OFFSET      = 32'h0000_0180;
    localparam logic [31:0] STATUS_RESET      = 32'h0000_ff01;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [4:0] INT_CODE = 5'd0;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_MFC0 = 2'd1,
        OP_MTC0 = 2'd2,
        OP_ERET = 2'd3
    } cop0_code_e;

    typedef enum logic [4:0] {
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12,
        EXC_TR   = 5'd13,
        EXC_NONE = 5'd31
    } exc_code_e;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        data_t status;
        data_t epc;
    } save_entry_t;

endpackage

// File: rtl/cp0_nested_irq_if.sv
// Pipeline-side bus between the ID/EX stage (master) and CP0 (slave).
interface cp0_nested_irq_if
    import cp0_nested_irq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W,
    parameter int unsigned NUM_IRQ    = 6
);
    logic                  enable;
    cop0_code_e            op_code;
    exc_code_e             exc_code;
    logic [NUM_IRQ-1:0]    irq;
    logic [DATA_WIDTH-1:0] pc;
    logic [4:0]            addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  e_jump;
    logic [DATA_WIDTH-1:0] epc;

    modport master (
        output enable, op_code, exc_code, irq, pc, addr, w_data,
        input  r_data, e_jump, epc
    );

    modport slave (
        input  enable, op_code, exc_code, irq, pc, addr, w_data,
        output r_data, e_jump, epc
    );
endinterface

// File: rtl/cp0_nested_irq_save_stack.sv
// LIFO of saved {Status,EPC} pairs for nested exceptions; push ignored when full, pop ignored when empty.
module cp0_nested_irq_save_stack
    import cp0_nested_irq_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = save_entry_t
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  entry_t push_data,
    output entry_t top,
    output logic   full,
    output logic   empty
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [CNT_W-1:0] level;

    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);
    assign top   = empty ? '0 : mem[IDX_W'(level - 1'b1)];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= '0;
        end else if (push && !full) begin
            level <= level + 1'b1;
        end else if (pop && !empty) begin
            level <= level - 1'b1;
        end
    end

    // Storage needs no reset: only slots below level are ever read.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[IDX_W'(level)] <= push_data;
        end
    end
endmodule

// File: rtl/cp0_nested_irq.sv
// CP0 with exceptions, level IRQs, Count/Compare timer and a nested {Status,EPC} save stack.
module cp0_nested_irq
    import cp0_nested_irq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_W,
    parameter int unsigned NUM_IRQ     = 6,
    parameter int unsigned STACK_DEPTH = 4
) (
    input logic             clock,
    input logic             reset,
    cp0_nested_irq_if.slave bus
);
    localparam int unsigned PEND_LO   = 16;
    localparam int unsigned PEND_W    = NUM_IRQ + 1;
    localparam int unsigned TIMER_BIT = PEND_LO + NUM_IRQ;
    localparam logic [DATA_WIDTH-1:0] VECTOR      = DATA_WIDTH'(EXCEPTION_ADDRESS + INSTR_OFFSET);
    localparam logic [DATA_WIDTH-1:0] INSTR_BYTES = DATA_WIDTH'(INSTR_WIDTH / 8);

    logic [DATA_WIDTH-1:0] regs [32];
    logic [DATA_WIDTH-1:0] count_n, compare_n, status_n, cause_n, epc_n;
    logic                  live, mtc0, eret, special;
    logic                  sync_ok, irq_hit, want, take, over;
    logic [4:0]            code;
    save_entry_t           stack_top;
    logic                  stack_full, stack_empty;

    assign live    = bus.enable && !reset;
    assign mtc0    = live && (bus.op_code == OP_MTC0);
    assign eret    = live && (bus.op_code == OP_ERET);
    assign special = bus.addr inside {REG_COUNT, REG_COMPARE, REG_STATUS, REG_CAUSE, REG_EPC};

    // Take decision: a maskable sync exception beats any IRQ; all interrupt sources share IntCode.
    always_comb begin
        sync_ok = 1'b0;
        case (bus.exc_code)
            EXC_NONE: sync_ok = 1'b0;
            EXC_SYS:  sync_ok = !regs[REG_STATUS][8];
            EXC_BP:   sync_ok = !regs[REG_STATUS][9];
            EXC_TR:   sync_ok = !regs[REG_STATUS][10];
            default:  sync_ok = 1'b1;
        endcase
        irq_hit = |(regs[REG_CAUSE][PEND_LO +: PEND_W] & regs[REG_STATUS][PEND_LO +: PEND_W]);
        want    = live && (bus.op_code == OP_NONE) && regs[REG_STATUS][0] && (sync_ok || irq_hit);
        take    = want && !stack_full;
        over    = want && stack_full;
        code    = sync_ok ? bus.exc_code : INT_CODE;
    end

    assign bus.e_jump = take || eret;
    assign bus.epc    = eret ? regs[REG_EPC] + INSTR_BYTES :
                        take ? VECTOR : {DATA_WIDTH{1'bz}};
    assign bus.r_data = (live && bus.op_code == OP_MFC0) ? regs[bus.addr] : {DATA_WIDTH{1'bz}};

    // Next values of the architecturally special registers; later rules override earlier ones.
    always_comb begin
        count_n   = (mtc0 && bus.addr == REG_COUNT) ? bus.w_data : regs[REG_COUNT] + 1'b1;
        compare_n = (mtc0 && bus.addr == REG_COMPARE) ? bus.w_data : regs[REG_COMPARE];
        status_n  = (mtc0 && bus.addr == REG_STATUS) ? bus.w_data : regs[REG_STATUS];
        epc_n     = (mtc0 && bus.addr == REG_EPC) ? bus.w_data : regs[REG_EPC];
        cause_n   = regs[REG_CAUSE];
        cause_n[PEND_LO +: NUM_IRQ] = bus.irq;
        if (mtc0 && bus.addr == REG_COMPARE) begin
            cause_n[TIMER_BIT] = 1'b0;
        end else if (count_n == regs[REG_COMPARE]) begin
            cause_n[TIMER_BIT] = 1'b1;
        end
        if (mtc0 && bus.addr == REG_CAUSE) begin
            cause_n[DATA_WIDTH-1 -: 2] = bus.w_data[DATA_WIDTH-1 -: 2];
            cause_n[6:2]               = bus.w_data[6:2];
        end
        if (take) begin
            status_n[0]  = 1'b0;
            cause_n[6:2] = code;
            epc_n        = bus.pc;
        end
        if (over) begin
            cause_n[DATA_WIDTH-1] = 1'b1;
        end
        if (eret) begin
            if (stack_empty) begin
                cause_n[DATA_WIDTH-2] = 1'b1;
            end else begin
                status_n = stack_top.status;
                epc_n    = stack_top.epc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[REG_STATUS] <= DATA_WIDTH'(STATUS_RESET);
        end else if (live) begin
            if (mtc0 && !special) begin
                regs[bus.addr] <= bus.w_data;
            end
            regs[REG_COUNT]   <= count_n;
            regs[REG_COMPARE] <= compare_n;
            regs[REG_STATUS]  <= status_n;
            regs[REG_CAUSE]   <= cause_n;
            regs[REG_EPC]     <= epc_n;
        end
    end

    cp0_nested_irq_save_stack #(
        .DEPTH   (STACK_DEPTH),
        .entry_t (save_entry_t)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (take),
        .pop       (eret),
        .push_data (save_entry_t'{status: regs[REG_STATUS], epc: regs[REG_EPC]}),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );
endmodule
